// File: rtl/lbdr_pkg.sv
// Shared types and constants for the LBDR deroute routing unit.
package lbdr_pkg;

  typedef enum logic [2:0] {
    HEADER  = 3'b001,
    PAYLOAD = 3'b010,
    TAIL    = 3'b100
  } flit_t;

  // Bit positions inside port_req {L,S,W,E,N} and the 4-bit {S,W,E,N} masks
  localparam int P_N = 0;
  localparam int P_E = 1;
  localparam int P_W = 2;
  localparam int P_S = 3;
  localparam int P_L = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } state_t;

  // Lowest set bit wins, which matches the N > E > W > S priority order.
  function automatic logic [3:0] first_set4(input logic [3:0] v);
    first_set4 = v & (~v + 4'd1);
  endfunction

endpackage

// File: rtl/lbdr_route_comp.sv
// Combinational LBDR route computation: coordinate compare, minimal candidates,
// priority selection and optional deroute fallback.
module lbdr_route_comp
  import lbdr_pkg::*;
#(
  parameter int CW      = 2,
  parameter bit DEROUTE = 1'b1
) (
  input  logic [2*CW-1:0] cur_addr,
  input  logic [2*CW-1:0] dst_addr,
  input  logic [7:0]      rxy,
  input  logic [3:0]      cx,
  input  logic [3:0]      dr,
  output logic [4:0]      route_oh,
  output logic            routable
);

  logic [CW-1:0] xc, yc, xd, yd;
  logic          n1, s1, e1, w1, is_local;
  logic [3:0]    cand;
  logic [3:0]    dr_ok;

  assign xc = cur_addr[CW-1:0];
  assign yc = cur_addr[2*CW-1:CW];
  assign xd = dst_addr[CW-1:0];
  assign yd = dst_addr[2*CW-1:CW];

  assign n1 = yd < yc;
  assign s1 = yc < yd;
  assign e1 = xc < xd;
  assign w1 = xd < xc;
  assign is_local = ~n1 & ~e1 & ~w1 & ~s1;

  // rxy bits: 0 Rne, 1 Rnw, 2 Ren, 3 Res, 4 Rwn, 5 Rws, 6 Rse, 7 Rsw
  assign cand[P_N] = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy[0]) | (n1 & w1 & rxy[1])) & cx[0];
  assign cand[P_E] = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy[2]) | (e1 & s1 & rxy[3])) & cx[1];
  assign cand[P_W] = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy[4]) | (w1 & s1 & rxy[5])) & cx[2];
  assign cand[P_S] = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy[6]) | (s1 & w1 & rxy[7])) & cx[3];

  assign dr_ok = dr & cx;

  always_comb begin
    route_oh = '0;
    routable = 1'b0;
    if (is_local) begin
      route_oh[P_L] = 1'b1;
      routable      = 1'b1;
    end else if (|cand) begin
      route_oh[3:0] = first_set4(cand);
      routable      = 1'b1;
    end else if (DEROUTE && (|dr_ok)) begin
      route_oh[3:0] = first_set4(dr_ok);
      routable      = 1'b1;
    end
  end

endmodule

// File: rtl/lbdr_dr_router.sv
// Per-input-port LBDR router: run-time config registers and packet FSM with
// request/grant handshake to the switch allocator.
//   state | meaning
//   IDLE  | waiting for a header; config writes accepted
//   BUSY  | route latched on port_req, flits popped on grant until TAIL
//   DROP  | unroutable packet, flits popped freely until TAIL
module lbdr_dr_router
  import lbdr_pkg::*;
#(
  parameter int              CW       = 2,
  parameter bit              DEROUTE  = 1'b1,
  parameter logic [7:0]      RST_RXY  = 8'd60,
  parameter logic [3:0]      RST_CX   = 4'd15,
  parameter logic [2*CW-1:0] RST_ADDR = (2*CW)'(5)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [7:0]      cfg_rxy,
  input  logic [3:0]      cfg_cx,
  input  logic [3:0]      cfg_dr,
  input  logic [2*CW-1:0] cfg_addr,
  input  logic            flit_valid,
  input  logic [2:0]      flit_id,
  input  logic [2*CW-1:0] dst_addr,
  output logic            flit_pop,
  output logic [4:0]      port_req,
  input  logic            grant,
  output logic            busy,
  output logic            route_err,
  output logic            proto_err
);

  state_t          state_q, state_d;
  logic [4:0]      port_req_q, port_req_d;
  logic            hdr_pend_q, hdr_pend_d;
  logic [7:0]      rxy_q, rxy_d;
  logic [3:0]      cx_q, cx_d;
  logic [3:0]      dr_q, dr_d;
  logic [2*CW-1:0] addr_q, addr_d;
  logic            route_err_q, route_err_d;
  logic            proto_err_q, proto_err_d;

  logic [4:0] route_oh;
  logic       routable;
  logic       is_hdr, is_tail;

  assign is_hdr  = (flit_id == HEADER);
  assign is_tail = (flit_id == TAIL);

  lbdr_route_comp #(
    .CW      (CW),
    .DEROUTE (DEROUTE)
  ) u_route (
    .cur_addr (addr_q),
    .dst_addr (dst_addr),
    .rxy      (rxy_q),
    .cx       (cx_q),
    .dr       (dr_q),
    .route_oh (route_oh),
    .routable (routable)
  );

  always_comb begin
    state_d     = state_q;
    port_req_d  = port_req_q;
    hdr_pend_d  = hdr_pend_q;
    rxy_d       = rxy_q;
    cx_d        = cx_q;
    dr_d        = dr_q;
    addr_d      = addr_q;
    route_err_d = 1'b0;
    proto_err_d = 1'b0;
    flit_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          rxy_d  = cfg_rxy;
          cx_d   = cfg_cx;
          dr_d   = cfg_dr;
          addr_d = cfg_addr;
        end
        if (flit_valid) begin
          if (is_hdr) begin
            // The header stays in the FIFO; it is popped as the first flit of the packet.
            hdr_pend_d = 1'b1;
            if (routable) begin
              port_req_d = route_oh;
              state_d    = BUSY;
            end else begin
              route_err_d = 1'b1;
              state_d     = DROP;
            end
          end else begin
            proto_err_d = 1'b1;
            flit_pop    = 1'b1;
          end
        end
      end
      BUSY: begin
        flit_pop = grant & flit_valid;
        if (flit_pop) begin
          hdr_pend_d = 1'b0;
          if (is_hdr && !hdr_pend_q) proto_err_d = 1'b1;
          if (is_tail) begin
            state_d    = IDLE;
            port_req_d = '0;
          end
        end
      end
      DROP: begin
        flit_pop = flit_valid;
        if (flit_pop) begin
          hdr_pend_d = 1'b0;
          if (is_tail) state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        port_req_d = '0;
        hdr_pend_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      port_req_q  <= '0;
      hdr_pend_q  <= 1'b0;
      rxy_q       <= RST_RXY;
      cx_q        <= RST_CX;
      dr_q        <= 4'b0000;
      addr_q      <= RST_ADDR;
      route_err_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_req_q  <= port_req_d;
      hdr_pend_q  <= hdr_pend_d;
      rxy_q       <= rxy_d;
      cx_q        <= cx_d;
      dr_q        <= dr_d;
      addr_q      <= addr_d;
      route_err_q <= route_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign port_req  = port_req_q;
  assign busy      = (state_q != IDLE);
  assign route_err = route_err_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_lbdr_dr_router.sv
// Self-checking bench for lbdr_dr_router: directed scenarios plus randomized
// routing checked against a rule-level reference model.
module tb_lbdr_dr_router;
  import lbdr_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_rxy = 8'd60;
  logic [3:0] cfg_cx = 4'd15;
  logic [3:0] cfg_dr = 4'd0;
  logic [3:0] cfg_addr = 4'd5;
  logic       flit_valid = 1'b0;
  logic [2:0] flit_id = 3'b000;
  logic [3:0] dst_addr = 4'd0;
  logic       grant = 1'b0;

  logic       flit_pop, busy, route_err, proto_err;
  logic [4:0] port_req;
  logic       nd_flit_pop, nd_busy, nd_route_err, nd_proto_err;
  logic [4:0] nd_port_req;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_rxy;
  logic [3:0] m_cx, m_dr, m_addr;

  always #5 clk = ~clk;

  lbdr_dr_router #(.CW(2), .DEROUTE(1'b1)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_rxy(cfg_rxy), .cfg_cx(cfg_cx),
    .cfg_dr(cfg_dr), .cfg_addr(cfg_addr), .flit_valid(flit_valid), .flit_id(flit_id),
    .dst_addr(dst_addr), .flit_pop(flit_pop), .port_req(port_req), .grant(grant),
    .busy(busy), .route_err(route_err), .proto_err(proto_err)
  );

  lbdr_dr_router #(.CW(2), .DEROUTE(1'b0)) dut_nd (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_rxy(cfg_rxy), .cfg_cx(cfg_cx),
    .cfg_dr(cfg_dr), .cfg_addr(cfg_addr), .flit_valid(flit_valid), .flit_id(flit_id),
    .dst_addr(dst_addr), .flit_pop(nd_flit_pop), .port_req(nd_port_req), .grant(grant),
    .busy(nd_busy), .route_err(nd_route_err), .proto_err(nd_proto_err)
  );

  // Reference: returns the one-hot {L,S,W,E,N} request, or 0 when the packet is dropped.
  function automatic logic [4:0] model_route(input logic [3:0] cur, input logic [3:0] dst,
                                             input logic [7:0] rxy, input logic [3:0] cx,
                                             input logic [3:0] dr, input bit der);
    int  xc, yc, xd, yd;
    bit  go_n, go_s, go_e, go_w, ok_n, ok_e, ok_w, ok_s;
    xc = cur % 4; yc = cur / 4; xd = dst % 4; yd = dst / 4;
    go_n = yd < yc; go_s = yd > yc; go_e = xd > xc; go_w = xd < xc;
    if (!go_n && !go_s && !go_e && !go_w) return 5'b10000;
    ok_n = go_n && cx[0] && (go_e ? rxy[0] : (go_w ? rxy[1] : 1'b1));
    ok_e = go_e && cx[1] && (go_n ? rxy[2] : (go_s ? rxy[3] : 1'b1));
    ok_w = go_w && cx[2] && (go_n ? rxy[4] : (go_s ? rxy[5] : 1'b1));
    ok_s = go_s && cx[3] && (go_e ? rxy[6] : (go_w ? rxy[7] : 1'b1));
    if (ok_n) return 5'b00001;
    if (ok_e) return 5'b00010;
    if (ok_w) return 5'b00100;
    if (ok_s) return 5'b01000;
    if (der) begin
      for (int i = 0; i < 4; i++)
        if (dr[i] && cx[i]) return 5'(1 << i);
    end
    return 5'b00000;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_defaults();
    m_rxy = 8'd60; m_cx = 4'd15; m_dr = 4'd0; m_addr = 4'd5;
  endtask

  task automatic write_cfg(input logic [7:0] rxy, input logic [3:0] cx,
                           input logic [3:0] dr, input logic [3:0] addr);
    cfg_rxy = rxy; cfg_cx = cx; cfg_dr = dr; cfg_addr = addr; cfg_we = 1'b1;
    cyc();
    cfg_we = 1'b0;
    m_rxy = rxy; m_cx = cx; m_dr = dr; m_addr = addr;
  endtask

  task automatic test_reset();
    flit_valid = 1'b0; grant = 1'b0;
    #2 rst = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0 || port_req !== 5'b0 || flit_pop !== 1'b0 || route_err !== 1'b0 || proto_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b port_req=%b pop=%b route_err=%b proto_err=%b, required all zero",
               busy, port_req, flit_pop, route_err, proto_err);
    end
    cyc(); cyc();
    rst = 1'b1;
    model_defaults();
    cyc();
  endtask

  task automatic test_local();
    dst_addr = 4'd5; flit_id = HEADER; flit_valid = 1'b1; grant = 1'b0;
    #1;
    checks++;
    if (flit_pop !== 1'b0) begin failures++; $display("FAIL local_hdr_nopop: got %b required 0", flit_pop); end
    cyc();
    checks++;
    if (port_req !== 5'b10000 || busy !== 1'b1) begin
      failures++; $display("FAIL local_req: port_req=%b busy=%b required 10000/1", port_req, busy);
    end
    grant = 1'b1;
    #1;
    checks++;
    if (flit_pop !== 1'b1) begin failures++; $display("FAIL local_pop_hdr: got %b required 1", flit_pop); end
    cyc();
    flit_id = TAIL;
    cyc();
    flit_valid = 1'b0; grant = 1'b0;
    checks++;
    if (busy !== 1'b0 || port_req !== 5'b0) begin
      failures++; $display("FAIL local_tail_idle: busy=%b port_req=%b required 0/00000", busy, port_req);
    end
  endtask

  task automatic test_north_stall();
    int pops = 0;
    logic [2:0] seq [3];
    seq[0] = HEADER; seq[1] = PAYLOAD; seq[2] = TAIL;
    dst_addr = 4'd1; flit_id = HEADER; flit_valid = 1'b1; grant = 1'b0;
    cyc();
    checks++;
    if (port_req !== 5'b00001) begin failures++; $display("FAIL north_req: got %b required 00001", port_req); end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (flit_pop !== 1'b0 || port_req !== 5'b00001) begin
        failures++; $display("FAIL north_stall: pop=%b port_req=%b required 0/00001", flit_pop, port_req);
      end
      cyc();
    end
    grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flit_id = seq[i];
      #1;
      if (flit_pop) pops++;
      checks++;
      if (port_req !== 5'b00001) begin failures++; $display("FAIL north_hold: got %b required 00001", port_req); end
      cyc();
    end
    flit_valid = 1'b0; grant = 1'b0;
    checks++;
    if (pops != 3 || busy !== 1'b0 || port_req !== 5'b0) begin
      failures++; $display("FAIL north_pops: pops=%0d busy=%b port_req=%b required 3/0/00000", pops, busy, port_req);
    end
  endtask

  task automatic test_turns();
    logic [7:0] t_rxy [3];
    logic [3:0] t_dr  [3];
    t_rxy[0] = 8'd62; t_dr[0] = 4'b0000;
    t_rxy[1] = 8'd60; t_dr[1] = 4'b0000;
    t_rxy[2] = 8'd44; t_dr[2] = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      logic [4:0] exp, exp_nd;
      write_cfg(t_rxy[i], 4'd15, t_dr[i], 4'd5);
      exp    = model_route(m_addr, 4'd0, m_rxy, m_cx, m_dr, 1'b1);
      exp_nd = model_route(m_addr, 4'd0, m_rxy, m_cx, m_dr, 1'b0);
      dst_addr = 4'd0; flit_id = HEADER; flit_valid = 1'b1; grant = 1'b0;
      cyc();
      checks++;
      if (port_req !== exp || nd_port_req !== exp_nd || route_err !== 1'b0 || nd_route_err !== (exp_nd == 5'b0)) begin
        failures++;
        $display("FAIL turn_%0d: port_req=%b nd_port_req=%b route_err=%b nd_route_err=%b required %b/%b/0/%b",
                 i, port_req, nd_port_req, route_err, nd_route_err, exp, exp_nd, exp_nd == 5'b0);
      end
      grant = 1'b1;
      cyc();
      flit_id = TAIL;
      cyc();
      flit_valid = 1'b0; grant = 1'b0;
      checks++;
      if (busy !== 1'b0 || nd_busy !== 1'b0) begin
        failures++; $display("FAIL turn_%0d_idle: busy=%b nd_busy=%b required 0/0", i, busy, nd_busy);
      end
    end
    write_cfg(8'd60, 4'd15, 4'd0, 4'd5);
  endtask

  task automatic test_route_err();
    int pops = 0;
    logic [2:0] seq [3];
    seq[0] = HEADER; seq[1] = PAYLOAD; seq[2] = TAIL;
    write_cfg(8'd60, 4'b1110, 4'b0010, 4'd5);
    dst_addr = 4'd1; flit_id = HEADER; flit_valid = 1'b1; grant = 1'b1;
    cyc();
    checks++;
    if (nd_route_err !== 1'b1 || nd_port_req !== 5'b0 || nd_busy !== 1'b1) begin
      failures++; $display("FAIL drop_start: nd_route_err=%b nd_port_req=%b nd_busy=%b required 1/00000/1",
                           nd_route_err, nd_port_req, nd_busy);
    end
    checks++;
    if (port_req !== 5'b00010 || route_err !== 1'b0) begin
      failures++; $display("FAIL deroute_east: port_req=%b route_err=%b required 00010/0", port_req, route_err);
    end
    for (int i = 0; i < 3; i++) begin
      flit_id = seq[i];
      #1;
      if (nd_flit_pop) pops++;
      checks++;
      if (nd_port_req !== 5'b0 || (i > 0 && nd_route_err !== 1'b0)) begin
        failures++; $display("FAIL drop_flit_%0d: nd_port_req=%b nd_route_err=%b required 00000/0",
                             i, nd_port_req, nd_route_err);
      end
      cyc();
    end
    flit_valid = 1'b0; grant = 1'b0;
    checks++;
    if (pops != 3 || nd_busy !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL drop_end: pops=%0d nd_busy=%b busy=%b required 3/0/0", pops, nd_busy, busy);
    end
    write_cfg(8'd60, 4'd15, 4'd0, 4'd5);
  endtask

  task automatic test_proto();
    flit_id = PAYLOAD; flit_valid = 1'b1; grant = 1'b0;
    #1;
    checks++;
    if (flit_pop !== 1'b1) begin failures++; $display("FAIL proto_idle_pop: got %b required 1", flit_pop); end
    cyc();
    flit_valid = 1'b0;
    checks++;
    if (proto_err !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL proto_idle: proto_err=%b busy=%b required 1/0", proto_err, busy);
    end
    cyc();
    checks++;
    if (proto_err !== 1'b0) begin failures++; $display("FAIL proto_pulse_len: got %b required 0", proto_err); end
    dst_addr = 4'd1; flit_id = HEADER; flit_valid = 1'b1;
    cyc();
    // Config write while BUSY must be ignored.
    cfg_rxy = 8'd0; cfg_cx = 4'd0; cfg_dr = 4'd0; cfg_addr = 4'd0; cfg_we = 1'b1;
    grant = 1'b1;
    cyc();
    cfg_we = 1'b0;
    dst_addr = 4'd5;
    cyc();
    checks++;
    if (proto_err !== 1'b1 || port_req !== 5'b00001 || busy !== 1'b1) begin
      failures++; $display("FAIL proto_busy_hdr: proto_err=%b port_req=%b busy=%b required 1/00001/1",
                           proto_err, port_req, busy);
    end
    flit_id = TAIL;
    cyc();
    checks++;
    if (proto_err !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL proto_tail: proto_err=%b busy=%b required 0/0", proto_err, busy);
    end
    flit_id = HEADER; dst_addr = 4'd5; grant = 1'b0;
    cyc();
    checks++;
    if (port_req !== model_route(m_addr, 4'd5, m_rxy, m_cx, m_dr, 1'b1)) begin
      failures++; $display("FAIL cfg_busy_ignored: port_req=%b required 10000", port_req);
    end
    grant = 1'b1;
    cyc();
    flit_id = TAIL;
    cyc();
    flit_valid = 1'b0; grant = 1'b0;
  endtask

  task automatic test_reset_mid();
    dst_addr = 4'd1; flit_id = HEADER; flit_valid = 1'b1; grant = 1'b0;
    cyc();
    grant = 1'b1;
    cyc();
    flit_id = PAYLOAD;
    cyc();
    flit_id = TAIL; grant = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || port_req !== 5'b0 || nd_busy !== 1'b0) begin
      failures++; $display("FAIL reset_mid: busy=%b port_req=%b nd_busy=%b required 0/00000/0", busy, port_req, nd_busy);
    end
    #2 rst = 1'b1;
    model_defaults();
    flit_valid = 1'b0;
    cyc();
    dst_addr = 4'd5; flit_id = HEADER; flit_valid = 1'b1;
    cyc();
    checks++;
    if (port_req !== 5'b10000 || busy !== 1'b1) begin
      failures++; $display("FAIL after_reset_route: port_req=%b busy=%b required 10000/1", port_req, busy);
    end
    grant = 1'b1;
    cyc();
    flit_id = TAIL;
    cyc();
    flit_valid = 1'b0; grant = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [4:0] exp, exp_nd;
      logic [3:0] dst;
      write_cfg(8'($urandom), 4'($urandom), 4'($urandom), 4'($urandom_range(0, 15)));
      dst = 4'($urandom_range(0, 15));
      exp    = model_route(m_addr, dst, m_rxy, m_cx, m_dr, 1'b1);
      exp_nd = model_route(m_addr, dst, m_rxy, m_cx, m_dr, 1'b0);
      dst_addr = dst; flit_id = HEADER; flit_valid = 1'b1; grant = 1'b0;
      cyc();
      checks++;
      if (port_req !== exp || route_err !== (exp == 5'b0) || nd_port_req !== exp_nd || nd_route_err !== (exp_nd == 5'b0)) begin
        failures++;
        $display("FAIL rand_%0d addr=%h dst=%h rxy=%h cx=%h dr=%h: port_req=%b route_err=%b nd_port_req=%b nd_route_err=%b required %b/%b/%b/%b",
                 n, m_addr, dst, m_rxy, m_cx, m_dr, port_req, route_err, nd_port_req, nd_route_err,
                 exp, exp == 5'b0, exp_nd, exp_nd == 5'b0);
      end
      grant = 1'b1;
      cyc();
      flit_id = TAIL;
      cyc();
      flit_valid = 1'b0; grant = 1'b0;
      checks++;
      if (busy !== 1'b0 || nd_busy !== 1'b0) begin
        failures++; $display("FAIL rand_%0d_idle: busy=%b nd_busy=%b required 0/0", n, busy, nd_busy);
      end
    end
  endtask

  initial begin
    model_defaults();
    test_reset();
    test_local();
    test_north_stall();
    test_turns();
    test_route_err();
    test_proto();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
